// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined multiply unit and its unsigned multiplier core.
package mul_pkg;

  localparam int unsigned MUL_XLEN   = 32;
  localparam int unsigned MUL_PROD_W = 2 * MUL_XLEN;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_t;

  function automatic logic is_signed_a(input mul_op_t op);
    return op != MUL_HUU;
  endfunction

  function automatic logic is_signed_b(input mul_op_t op);
    return (op == MUL_LO) || (op == MUL_HSS);
  endfunction

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  function automatic logic [MUL_XLEN-1:0] magnitude(input logic [MUL_XLEN-1:0] x,
                                                     input logic              neg);
    return neg ? (~x + {{(MUL_XLEN-1){1'b0}}, 1'b1}) : x;
  endfunction

  function automatic logic [MUL_PROD_W-1:0] apply_sign(input logic [MUL_PROD_W-1:0] x,
                                                        input logic                neg);
    return neg ? (~x + {{(MUL_PROD_W-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/mul_pipe_unit_booth_mul.sv
// Combinational 32x32 unsigned multiplier: radix-4 Booth partial products reduced by a
// carry-save adder chain and one final carry-propagate add.
module BoothMul
  import mul_pkg::*;
(
  input  logic [MUL_XLEN-1:0]   a_i,
  input  logic [MUL_XLEN-1:0]   b_i,
  output logic [MUL_PROD_W-1:0] prod_o,
  output logic [MUL_XLEN/2:0]   dbg_shift_o
);

  // One extra group covers the zero-extended top bit of an unsigned multiplier.
  localparam int unsigned NumPp = MUL_XLEN / 2 + 1;
  localparam int unsigned ProdW = MUL_PROD_W;
  localparam logic [ProdW-1:0] ProdOne = {{(ProdW-1){1'b0}}, 1'b1};

  logic [MUL_XLEN+2:0] b_ext;
  logic [ProdW-1:0]    pp [NumPp];

  assign b_ext = {2'b00, b_i, 1'b0};

  for (genvar g = 0; g < NumPp; g++) begin : g_pp
    logic [2:0]       grp;
    logic             one;
    logic             two;
    logic             neg;
    logic [ProdW-1:0] mult;

    assign grp = b_ext[2*g +: 3];

    always_comb begin
      one = 1'b0;
      two = 1'b0;
      neg = 1'b0;
      unique case (grp)
        3'b001, 3'b010: one = 1'b1;
        3'b011:         two = 1'b1;
        3'b100: begin
          two = 1'b1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          one = 1'b1;
          neg = 1'b1;
        end
        default: ;
      endcase
    end

    always_comb begin
      mult = '0;
      if (one) begin
        mult = {{(ProdW-MUL_XLEN){1'b0}}, a_i};
      end else if (two) begin
        mult = {{(ProdW-MUL_XLEN-1){1'b0}}, a_i, 1'b0};
      end
      if (neg) begin
        mult = ~mult + ProdOne;
      end
    end

    assign pp[g]          = mult << (2 * g);
    assign dbg_shift_o[g] = two;
  end

  logic [ProdW-1:0] cs_sum;
  logic [ProdW-1:0] cs_carry;
  logic [ProdW-1:0] cs_maj;

  // Sum and carry are kept modulo 2^64; dropped carries out of the top are harmless.
  always_comb begin
    cs_sum   = pp[0];
    cs_carry = '0;
    cs_maj   = '0;
    for (int i = 1; i < NumPp; i++) begin
      cs_maj   = (cs_sum & cs_carry) | (cs_sum & pp[i]) | (cs_carry & pp[i]);
      cs_sum   = cs_sum ^ cs_carry ^ pp[i];
      cs_carry = cs_maj << 1;
    end
    prod_o = cs_sum + cs_carry;
  end

endmodule

// File: rtl/mul_pipe_unit.sv
// Three-stage pipelined M-extension multiply unit (magnitude / product / sign+select).
// Optional feature: define MUL_FLUSH_EN to add the flush port.
module mul_pipe_unit
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [MUL_XLEN-1:0] in_a,
  input  logic [MUL_XLEN-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MUL_XLEN-1:0] out_result,
  output logic [TAG_W-1:0]    out_tag
`ifdef MUL_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  logic adv;
  logic flush_w;

`ifdef MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign adv = ~out_valid | out_ready;

  // Stage A: operand magnitudes and result sign.
  logic                valid_a_q, valid_a_d;
  logic [MUL_XLEN-1:0] mag_a_q, mag_a_d;
  logic [MUL_XLEN-1:0] mag_b_q, mag_b_d;
  logic                neg_a_q, neg_a_d;
  mul_op_t             op_a_q, op_a_d;
  logic [TAG_W-1:0]    tag_a_q, tag_a_d;

  // Stage B: unsigned product.
  logic                  valid_b_q, valid_b_d;
  logic [MUL_PROD_W-1:0] prod_b_q, prod_b_d;
  logic                  neg_b_q, neg_b_d;
  mul_op_t               op_b_q, op_b_d;
  logic [TAG_W-1:0]      tag_b_q, tag_b_d;

  // Stage C: selected result word.
  logic                valid_c_q, valid_c_d;
  logic [MUL_XLEN-1:0] result_q, result_d;
  logic [TAG_W-1:0]    tag_c_q, tag_c_d;

  mul_op_t               in_op_e;
  logic                  sign_a;
  logic                  sign_b;
  logic [MUL_PROD_W-1:0] prod_raw;
  logic [MUL_PROD_W-1:0] prod_signed;

  assign in_op_e = mul_op_t'(in_op);
  assign sign_a  = is_signed_a(in_op_e) & in_a[MUL_XLEN-1];
  assign sign_b  = is_signed_b(in_op_e) & in_b[MUL_XLEN-1];

  BoothMul u_booth_mul (
    .a_i         (mag_a_q),
    .b_i         (mag_b_q),
    .prod_o      (prod_raw),
    .dbg_shift_o ()
  );

  assign prod_signed = apply_sign(prod_b_q, neg_b_q);

  // Bubbles advance like real operations; flush overrides any stall.
  always_comb begin
    valid_a_d = valid_a_q;
    valid_b_d = valid_b_q;
    valid_c_d = valid_c_q;
    if (adv) begin
      valid_a_d = in_valid;
      valid_b_d = valid_a_q;
      valid_c_d = valid_b_q;
    end
    if (flush_w) begin
      valid_a_d = 1'b0;
      valid_b_d = 1'b0;
      valid_c_d = 1'b0;
    end
  end

  always_comb begin
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_a_d  = neg_a_q;
    op_a_d   = op_a_q;
    tag_a_d  = tag_a_q;
    prod_b_d = prod_b_q;
    neg_b_d  = neg_b_q;
    op_b_d   = op_b_q;
    tag_b_d  = tag_b_q;
    result_d = result_q;
    tag_c_d  = tag_c_q;
    if (adv) begin
      mag_a_d  = magnitude(in_a, sign_a);
      mag_b_d  = magnitude(in_b, sign_b);
      neg_a_d  = sign_a ^ sign_b;
      op_a_d   = in_op_e;
      tag_a_d  = in_tag;
      prod_b_d = prod_raw;
      neg_b_d  = neg_a_q;
      op_b_d   = op_a_q;
      tag_b_d  = tag_a_q;
      result_d = (op_b_q == MUL_LO) ? prod_signed[MUL_XLEN-1:0]
                                    : prod_signed[MUL_PROD_W-1:MUL_XLEN];
      tag_c_d  = tag_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      valid_c_q <= 1'b0;
      result_q  <= '0;
      tag_c_q   <= '0;
    end else begin
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      valid_c_q <= valid_c_d;
      result_q  <= result_d;
      tag_c_q   <= tag_c_d;
    end
  end

  always_ff @(posedge clk) begin
    mag_a_q  <= mag_a_d;
    mag_b_q  <= mag_b_d;
    neg_a_q  <= neg_a_d;
    op_a_q   <= op_a_d;
    tag_a_q  <= tag_a_d;
    prod_b_q <= prod_b_d;
    neg_b_q  <= neg_b_d;
    op_b_q   <= op_b_d;
    tag_b_q  <= tag_b_d;
  end

  assign in_ready   = adv;
  assign out_valid  = valid_c_q;
  assign out_result = result_q;
  assign out_tag    = tag_c_q;

endmodule
